// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_pkg : mode constants and counter direction type for pwm_multi     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/pwm_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_multi_if : config handshake, enable and PWM output bundle         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  import pwm_pkg::*;

  logic                      enable;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [WIDTH-1:0]          cfg_period;
  logic                      cfg_center;
  logic [CHANNELS*WIDTH-1:0] cfg_levels;
  logic                      period_end;
  logic                      cfg_applied;
  logic [CHANNELS-1:0]       out;

  modport master (
    output enable, cfg_valid, cfg_period, cfg_center, cfg_levels,
    input  cfg_ready, period_end, cfg_applied, out
  );

  modport slave (
    input  enable, cfg_valid, cfg_period, cfg_center, cfg_levels,
    output cfg_ready, period_end, cfg_applied, out
  );
endinterface
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_chan : per-channel compare, polarity invert and output register   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic INVERT_BIT = 1'b0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             enable,
  input  wire logic [WIDTH-1:0] count,
  input  wire logic [WIDTH-1:0] level,
  output logic                  out
);

  logic out_d;
  logic out_q;

  always_comb begin
    out_d = INVERT_BIT;
    if (enable) begin
      out_d = (count < level) ^ INVERT_BIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= INVERT_BIT;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_multi : shared-counter multi-channel PWM with shadowed config     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  WIDTH    = 8,
  parameter int                  CHANNELS = 4,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  wire logic  clk,
  input  wire logic  reset,
  pwm_multi_if.slave bus
);

  dir_e                      dir_q, dir_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic                      pending_q, pending_d;
  logic [WIDTH-1:0]          sh_period_q, sh_period_d;
  logic                      sh_center_q, sh_center_d;
  logic [CHANNELS*WIDTH-1:0] sh_levels_q, sh_levels_d;
  logic [WIDTH-1:0]          act_period_q, act_period_d;
  logic                      act_center_q, act_center_d;
  logic [CHANNELS*WIDTH-1:0] act_levels_q, act_levels_d;

  logic                      w_last;
  logic                      w_boundary;
  logic                      w_apply;
  logic                      w_accept;
  logic [CHANNELS-1:0]       w_out;

  // Center mode with P==1 peaks on the last cycle, so count==1 is the end whatever the direction.
  always_comb begin
    w_last = (count_q == act_period_q);
    if (act_center_q == MODE_CENTER) begin
      w_last = (act_period_q == '0) ||
               ((count_q == WIDTH'(1)) &&
                ((dir_q == DIR_DOWN) || (act_period_q == WIDTH'(1))));
    end
  end

  assign w_boundary = bus.enable && w_last;
  assign w_apply    = pending_q && (w_boundary || !bus.enable);
  assign w_accept   = bus.cfg_valid && !pending_q;

  // Counter / direction FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // Counter / direction FSM: next state
  always_comb begin
    count_d = count_q + WIDTH'(1);
    dir_d   = dir_q;
    if (!bus.enable || w_boundary) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (act_center_q == MODE_CENTER) begin
      if (dir_q == DIR_DOWN) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == act_period_q) begin
        count_d = count_q - WIDTH'(1);
        dir_d   = DIR_DOWN;
      end
    end
  end

  // Counter / direction FSM: outputs
  always_comb begin
    bus.cfg_ready   = !pending_q;
    bus.period_end  = w_boundary;
    bus.cfg_applied = w_apply;
  end

  // Accept and apply never coincide: accept needs an empty shadow, apply a full one.
  always_comb begin
    pending_d    = pending_q;
    sh_period_d  = sh_period_q;
    sh_center_d  = sh_center_q;
    sh_levels_d  = sh_levels_q;
    act_period_d = act_period_q;
    act_center_d = act_center_q;
    act_levels_d = act_levels_q;
    if (w_accept) begin
      sh_period_d = bus.cfg_period;
      sh_center_d = bus.cfg_center;
      sh_levels_d = bus.cfg_levels;
      pending_d   = 1'b1;
    end else if (w_apply) begin
      act_period_d = sh_period_q;
      act_center_d = sh_center_q;
      act_levels_d = sh_levels_q;
      pending_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 1'b0;
      sh_period_q  <= '0;
      sh_center_q  <= MODE_EDGE;
      sh_levels_q  <= '0;
      act_period_q <= '1;
      act_center_q <= MODE_EDGE;
      act_levels_q <= '0;
    end else begin
      pending_q    <= pending_d;
      sh_period_q  <= sh_period_d;
      sh_center_q  <= sh_center_d;
      sh_levels_q  <= sh_levels_d;
      act_period_q <= act_period_d;
      act_center_q <= act_center_d;
      act_levels_q <= act_levels_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_chan #(
      .WIDTH      (WIDTH),
      .INVERT_BIT (INVERT[i])
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .count  (count_q),
      .level  (act_levels_q[i*WIDTH +: WIDTH]),
      .out    (w_out[i])
    );
  end

  assign bus.out = w_out;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_multi : randomized scoreboard bench against a phase-based model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pwm_multi;

  localparam int              WIDTH = 8;
  localparam int              CH    = 4;
  localparam logic [CH-1:0]   INV   = 4'b0101;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_multi_if #(.WIDTH(WIDTH), .CHANNELS(CH)) bus ();

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CH), .INVERT(INV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          chk;
    logic        pe;
    logic        ap;
    logic        rdy;
    logic [CH-1:0] o;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // stimulus held for the next clock edge
  bit s_rst, s_en, s_v, s_c;
  int s_P;
  int s_lev[CH];

  // reference model: active/shadow config and position t inside the current period
  bit            m_valid;
  int            mP, sP, t;
  bit            mC, sC, pend, last_acc;
  int            mLev[CH], sLev[CH];
  logic [CH-1:0] mOut;
  logic [CH-1:0] inv_v;

  task automatic model_reset();
    mP = 255; mC = 1'b0; t = 0; pend = 1'b0; mOut = inv_v;
    for (int i = 0; i < CH; i++) mLev[i] = 0;
    m_valid = 1'b1;
  endtask

  task automatic tick();
    int   len, cnt;
    bit   bnd, ap, acc;
    exp_t e;
    reset          = s_rst;
    bus.enable     = s_en;
    bus.cfg_valid  = s_v;
    bus.cfg_center = s_c;
    bus.cfg_period = s_P[WIDTH-1:0];
    for (int i = 0; i < CH; i++) bus.cfg_levels[i*WIDTH +: WIDTH] = s_lev[i][WIDTH-1:0];
    #1;
    len = mC ? ((mP == 0) ? 1 : 2 * mP) : mP + 1;
    cnt = (mC && t > mP) ? 2 * mP - t : t;
    bnd = s_en && (t == len - 1);
    ap  = pend && (!s_en || bnd);
    e.chk = m_valid; e.pe = bnd; e.ap = ap; e.rdy = !pend; e.o = mOut;
    q.push_back(e);
    last_acc = 1'b0;
    if (s_rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) mOut[i] = s_en ? ((cnt < mLev[i]) ^ inv_v[i]) : inv_v[i];
      acc = s_v && !pend;
      if (ap) begin
        mP = sP; mC = sC; pend = 1'b0;
        for (int i = 0; i < CH; i++) mLev[i] = sLev[i];
      end
      if (acc) begin
        sP = s_P; sC = s_c; pend = 1'b1; last_acc = 1'b1;
        for (int i = 0; i < CH; i++) sLev[i] = s_lev[i];
      end
      t = (!s_en || bnd) ? 0 : t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_cfg(input int p, input bit c, input int l0, input int l1,
                         input int l2, input int l3);
    s_P = p; s_c = c;
    s_lev[0] = l0; s_lev[1] = l1; s_lev[2] = l2; s_lev[3] = l3;
  endtask

  task automatic rand_cfg();
    s_P = $urandom_range(0, 12);
    s_c = 1'($urandom_range(0, 1));
    for (int i = 0; i < CH; i++) s_lev[i] = $urandom_range(0, s_P + 2);
  endtask

  // offer the staged config until the model reports it taken
  task automatic send_cfg();
    int waited = 0;
    s_v = 1'b1;
    do begin
      tick();
      waited++;
    end while (!last_acc && waited < 2000);
    s_v = 1'b0;
    if (!last_acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL cfg_accept_timeout: accepted=0 required=1 after %0d cycles", waited);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        n_checks += 4;
        if (bus.period_end !== e.pe) begin
          n_errors++;
          $display("FAIL period_end @%0t: got %b want %b", $time, bus.period_end, e.pe);
        end
        if (bus.cfg_applied !== e.ap) begin
          n_errors++;
          $display("FAIL cfg_applied @%0t: got %b want %b", $time, bus.cfg_applied, e.ap);
        end
        if (bus.cfg_ready !== e.rdy) begin
          n_errors++;
          $display("FAIL cfg_ready @%0t: got %b want %b", $time, bus.cfg_ready, e.rdy);
        end
        if (bus.out !== e.o) begin
          n_errors++;
          $display("FAIL out @%0t: got %b want %b", $time, bus.out, e.o);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    inv_v = INV;
    m_valid = 1'b0;
    mP = 255; mC = 1'b0; t = 0; pend = 1'b0; mOut = inv_v; last_acc = 1'b0;
    sP = 0; sC = 1'b0;
    for (int i = 0; i < CH; i++) begin mLev[i] = 0; sLev[i] = 0; end
    s_rst = 1'b1; s_en = 1'b0; s_v = 1'b0;
    set_cfg(0, 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    run(2);
    s_rst = 1'b0;
    run(3);

    // edge P=9, levels 0/3/9/10, applied at the 256-cycle reset-period boundary
    s_en = 1'b1;
    set_cfg(9, 1'b0, 0, 3, 9, 10);
    send_cfg();
    run(300);

    // center P=4, level 2 on every channel
    set_cfg(4, 1'b1, 2, 2, 2, 2);
    send_cfg();
    run(40);

    // mid-period level change 3 -> 7, with a second offer while pending
    set_cfg(9, 1'b0, 3, 3, 3, 3);
    send_cfg();
    run(25);
    set_cfg(9, 1'b0, 7, 7, 7, 7);
    send_cfg();
    set_cfg(5, 1'b1, 1, 1, 1, 1);
    s_v = 1'b1;
    run(3);
    s_v = 1'b0;
    run(30);

    // enable=0 with a pending shadow
    set_cfg(200, 1'b0, 50, 60, 70, 80);
    send_cfg();
    run(4);
    s_en = 1'b0;
    run(5);
    s_en = 1'b1;
    run(10);

    // reset mid-period with a pending shadow
    set_cfg(6, 1'b1, 1, 2, 3, 4);
    send_cfg();
    run(2);
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    run(5);

    // randomized traffic: enable toggles, rare resets, data wiggled while not ready
    set_cfg(7, 1'b0, 2, 4, 6, 9);
    send_cfg();
    for (int k = 0; k < 3000; k++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) s_en = ~s_en;
      if (!s_v) begin
        if ($urandom_range(0, 7) == 0) begin
          rand_cfg();
          s_v = 1'b1;
        end
      end else if (pend && $urandom_range(0, 3) == 0) begin
        rand_cfg();
      end
      tick();
      if (last_acc) s_v = 1'b0;
    end
    s_rst = 1'b0;
    s_v   = 1'b0;
    run(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
